// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : la_pkg
//  Purpose  : Shared types and constants for the logic analyzer digital core.
//             Provides the capture state encoding, the channel count and the
//             default channel RAM geometry.
//  Revision : 1.0 - initial release
// ============================================================================
package la_pkg;

  localparam int NUM_CH      = 5;
  localparam int ENTRIES_DEF = 384;
  localparam int ADDR_W_DEF  = 9;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_RUN  = 2'd1,
    CAP_DONE = 2'd2
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/wrap_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : wrap_cnt
//  Purpose  : Modulo-MOD up counter with synchronous clear and enable.
//             Also exposes the value the counter will hold after the next
//             clock, so callers can latch "the address after this write".
//  Ports    : clk, rst_n     - clock, asynchronous active-low reset
//             clr            - load 0 on the next clock (wins over en)
//             en             - advance by one, wrapping MOD-1 -> 0
//             count          - current value
//             count_nxt      - value after the next clock edge
//  Revision : 1.0 - initial release
// ============================================================================
module wrap_cnt #(
  parameter int MOD = 384,
  parameter int W   = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt
);

  localparam logic [W-1:0] C_LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count     = cnt_q;
  assign count_nxt = cnt_d;

endmodule
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : capture_ctrl
//  Purpose  : Capture controller of the logic analyzer. Arms the channel
//             trigger blocks once enough pre-trigger history is stored,
//             combines channel and protocol triggers, drives the circular
//             RAM write port, counts post-trigger samples and latches the
//             oldest-sample address when the capture completes.
//  Ports    : clk, rst_n     - clock, asynchronous active-low reset
//             run            - capture enable (rise starts, fall ends/aborts)
//             wrt_smpl       - one-cycle sample strobe
//             ch_trig        - per-channel trigger outputs
//             prot_trig      - protocol trigger (1 when unused)
//             trig_pos       - number of samples to store after the trigger
//             armed          - edge triggers may fire
//             triggered      - trigger seen in the current capture
//             we, waddr      - channel RAM write enable / address
//             trig_addr      - oldest stored sample, latched at capture end
//             capture_done   - capture complete, RAM readable
//  Revision : 1.0 - initial release
// ============================================================================
module capture_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              wrt_smpl,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic              prot_trig,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              armed,
  output logic              triggered,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done
);

  localparam logic [1:0] S_IDLE = CAP_IDLE;
  localparam logic [1:0] S_RUN  = CAP_RUN;
  localparam logic [1:0] S_DONE = CAP_DONE;

  // smpl_cnt must be able to hold ENTRIES itself (saturation value).
  localparam int                CNT_W  = $clog2(ENTRIES + 1);
  localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(ENTRIES);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(ENTRIES - 1);

  logic [1:0]        state_q,     state_d;
  logic [CNT_W-1:0]  smpl_cnt_q,  smpl_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q,  post_cnt_d;
  logic              armed_q,     armed_d;
  logic              trig_q,      trig_d;
  logic              done_q,      done_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;

  logic [ADDR_W-1:0] eff_pos;
  logic              trig_set;
  logic              we_w;
  logic              waddr_clr;
  logic              waddr_en;
  logic [ADDR_W-1:0] waddr_cur;
  logic [ADDR_W-1:0] waddr_nxt;

  // Post-trigger length can never exceed the buffer minus the trigger sample.
  assign eff_pos  = (int'(trig_pos) >= ENTRIES) ? C_LAST : trig_pos;
  assign trig_set = armed_q & (&ch_trig) & prot_trig;

  wrap_cnt #(
    .MOD (ENTRIES),
    .W   (ADDR_W)
  ) u_waddr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (waddr_clr),
    .en        (waddr_en),
    .count     (waddr_cur),
    .count_nxt (waddr_nxt)
  );

  always_comb begin
    state_d     = state_q;
    smpl_cnt_d  = smpl_cnt_q;
    post_cnt_d  = post_cnt_q;
    armed_d     = armed_q;
    trig_d      = trig_q;
    done_d      = done_q;
    trig_addr_d = trig_addr_q;
    waddr_clr   = 1'b0;
    waddr_en    = 1'b0;
    we_w        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d    = S_RUN;
          waddr_clr  = 1'b1;
          smpl_cnt_d = '0;
          post_cnt_d = '0;
          armed_d    = 1'b0;
          trig_d     = 1'b0;
          done_d     = 1'b0;
        end
      end

      S_RUN: begin
        // The write is performed even on the abort or completion cycle.
        we_w     = wrt_smpl;
        waddr_en = wrt_smpl;

        if (wrt_smpl && (smpl_cnt_q != C_FULL)) begin
          smpl_cnt_d = smpl_cnt_q + CNT_W'(1);
        end

        // Evaluated on the post-write count so armed follows the write by 1 clk.
        if ((int'(smpl_cnt_d) + int'(eff_pos)) >= ENTRIES) begin
          armed_d = 1'b1;
        end

        if (trig_set) begin
          trig_d = 1'b1;
        end

        if (trig_q && wrt_smpl) begin
          post_cnt_d = post_cnt_q + ADDR_W'(1);
        end

        if (!run) begin
          state_d = S_IDLE;
          armed_d = 1'b0;
          trig_d  = 1'b0;
        end else if (trig_q && (post_cnt_d == eff_pos)) begin
          // waddr_nxt already includes a write on this cycle: it is the
          // slot to be overwritten next, i.e. the oldest stored sample.
          state_d     = S_DONE;
          trig_addr_d = waddr_nxt;
          done_d      = 1'b1;
          armed_d     = 1'b0;
        end
      end

      S_DONE: begin
        if (!run) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      smpl_cnt_q  <= '0;
      post_cnt_q  <= '0;
      armed_q     <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      smpl_cnt_q  <= smpl_cnt_d;
      post_cnt_q  <= post_cnt_d;
      armed_q     <= armed_d;
      trig_q      <= trig_d;
      done_q      <= done_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  assign armed        = armed_q;
  assign triggered    = trig_q;
  assign we           = we_w;
  assign waddr        = waddr_cur;
  assign trig_addr    = trig_addr_q;
  assign capture_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capture_ctrl
//  Purpose  : Directed self-checking bench for capture_ctrl with an 8-entry
//             buffer. Expected values are hand-derived from the intended
//             capture behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_capture_ctrl;

  localparam int ENTRIES = 8;
  localparam int ADDR_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              wrt_smpl;
  logic [4:0]        ch_trig;
  logic              prot_trig;
  logic [ADDR_W-1:0] trig_pos;
  logic              armed;
  logic              triggered;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;
  logic              capture_done;

  int n_checks = 0;
  int n_fails  = 0;

  capture_ctrl #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .wrt_smpl     (wrt_smpl),
    .ch_trig      (ch_trig),
    .prot_trig    (prot_trig),
    .trig_pos     (trig_pos),
    .armed        (armed),
    .triggered    (triggered),
    .we           (we),
    .waddr        (waddr),
    .trig_addr    (trig_addr),
    .capture_done (capture_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write1();
    wrt_smpl = 1'b1;
    cyc();
    wrt_smpl = 1'b0;
  endtask

  // One write followed by three idle clocks (one write every 4 clocks).
  task automatic write_slow();
    write1();
    repeat (3) cyc();
  endtask

  task automatic fire_trigger();
    ch_trig = 5'h1F;
    cyc();
    ch_trig = 5'h00;
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    wrt_smpl  = 1'b0;
    ch_trig   = 5'h00;
    prot_trig = 1'b1;
    trig_pos  = 3'd3;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    check_val("rst_armed", 32'(armed), 32'd0);
    check_val("rst_trig",  32'(triggered), 32'd0);
    check_val("rst_done",  32'(capture_done), 32'd0);
    check_val("rst_waddr", 32'(waddr), 32'd0);
    check_val("rst_taddr", 32'(trig_addr), 32'd0);

    // ---- Reset in the middle of a capture ----
    run = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) write1();
    check_val("mid_waddr5", 32'(waddr), 32'd5);
    check_val("mid_armed",  32'(armed), 32'd1);
    run      = 1'b0;
    rst_n    = 1'b0;
    wrt_smpl = 1'b1;
    #1;
    check_val("arst_waddr", 32'(waddr), 32'd0);
    check_val("arst_armed", 32'(armed), 32'd0);
    check_val("arst_we",    32'(we), 32'd0);
    wrt_smpl = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // ---- trig_pos=3, slow writes, early trigger ignored ----
    trig_pos = 3'd3;
    run      = 1'b1;
    cyc();
    ch_trig = 5'h1F;
    for (int i = 0; i < 4; i++) write_slow();
    ch_trig = 5'h00;
    check_val("early_armed", 32'(armed), 32'd0);
    check_val("early_trig",  32'(triggered), 32'd0);
    wrt_smpl = 1'b1;
    #1;
    check_val("run_we", 32'(we), 32'd1);
    cyc();
    wrt_smpl = 1'b0;
    check_val("armed_5th", 32'(armed), 32'd1);
    repeat (3) cyc();
    write_slow();
    check_val("pre_waddr6", 32'(waddr), 32'd6);
    fire_trigger();
    check_val("trig_rise", 32'(triggered), 32'd1);
    write_slow();
    write_slow();
    check_val("post2_done", 32'(capture_done), 32'd0);
    write1();
    check_val("post3_done",  32'(capture_done), 32'd1);
    check_val("post3_taddr", 32'(trig_addr), 32'd1);
    check_val("post3_waddr", 32'(waddr), 32'd1);
    check_val("done_armed",  32'(armed), 32'd0);
    wrt_smpl = 1'b1;
    #1;
    check_val("done_we", 32'(we), 32'd0);
    cyc();
    wrt_smpl = 1'b0;
    check_val("done_hold_waddr", 32'(waddr), 32'd1);
    run = 1'b0;
    cyc();
    check_val("idle_done_kept", 32'(capture_done), 32'd1);

    // ---- trig_pos=0: done one clock after triggered ----
    trig_pos = 3'd0;
    run      = 1'b1;
    cyc();
    check_val("restart_done_clr", 32'(capture_done), 32'd0);
    check_val("restart_trig_clr", 32'(triggered), 32'd0);
    for (int i = 0; i < 7; i++) write1();
    check_val("p0_armed7", 32'(armed), 32'd0);
    write1();
    check_val("p0_armed8", 32'(armed), 32'd1);
    fire_trigger();
    check_val("p0_trig",     32'(triggered), 32'd1);
    check_val("p0_not_done", 32'(capture_done), 32'd0);
    cyc();
    check_val("p0_done",  32'(capture_done), 32'd1);
    check_val("p0_taddr", 32'(trig_addr), 32'd0);
    run = 1'b0;
    cyc();

    // ---- Largest post-trigger length (15 clamps to 7; a 3-bit port holds 7) ----
    trig_pos = 3'd7;
    run      = 1'b1;
    cyc();
    write1();
    check_val("p7_armed1", 32'(armed), 32'd1);
    fire_trigger();
    check_val("p7_trig", 32'(triggered), 32'd1);
    for (int i = 0; i < 6; i++) write1();
    check_val("p7_done6", 32'(capture_done), 32'd0);
    write1();
    check_val("p7_done7",  32'(capture_done), 32'd1);
    check_val("p7_taddr",  32'(trig_addr), 32'd0);
    run = 1'b0;
    cyc();

    // ---- Abort after 12 writes, with a write on the abort cycle ----
    trig_pos = 3'd7;
    run      = 1'b1;
    cyc();
    for (int i = 0; i < 9; i++) write1();
    fire_trigger();
    for (int i = 0; i < 3; i++) write1();
    check_val("ab_waddr4", 32'(waddr), 32'd4);
    check_val("ab_trig",   32'(triggered), 32'd1);
    run      = 1'b0;
    wrt_smpl = 1'b1;
    #1;
    check_val("ab_we_last", 32'(we), 32'd1);
    cyc();
    check_val("ab_waddr5", 32'(waddr), 32'd5);
    check_val("ab_armed",  32'(armed), 32'd0);
    check_val("ab_trig0",  32'(triggered), 32'd0);
    check_val("ab_done0",  32'(capture_done), 32'd0);
    check_val("ab_we_off", 32'(we), 32'd0);
    wrt_smpl = 1'b0;
    cyc();

    // ---- Restart after abort ----
    run = 1'b1;
    cyc();
    check_val("rr_waddr0", 32'(waddr), 32'd0);
    write1();
    check_val("rr_waddr1", 32'(waddr), 32'd1);
    run = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
